fifo_wr_pkt_arb: RTL and testbench
==================================

FIFO_WR_PKT_ARB -- requirements
Module: fifo_wr_pkt_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_DATA_WIDTH, 32, word width on both requester ports and the FIFO port.
- C_MAX_PKT_WORDS, 1024, maximum words per packet; must be at most the return-FIFO write depth.
- C_TIMEOUT_CYCLES, 4096, number of idle cycles inside a packet before rollback.
- C_CNT_WIDTH, 16, width of the debug counters.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK_I, in, 1, the single clock; all logic is rising-edge.
- RST_N_I, in, 1, asynchronous active-low reset.
- S0_VALID_I / S1_VALID_I, in, 1, requester word valid.
- S0_DATA_I / S1_DATA_I, in, C_DATA_WIDTH, requester word.
- S0_LAST_I / S1_LAST_I, in, 1, final word of the packet.
- S0_ABORT_I / S1_ABORT_I, in, 1, requester cancels the current packet.
- S0_READY_O / S1_READY_O, out, 1, word accepted when VALID and READY are both high.
- FIFO_WR_EN_O, out, 1, write strobe to the return-capable FIFO.
- FIFO_WR_DATA_O, out, C_DATA_WIDTH, write data.
- FIFO_WR_SUCC_O, out, 1, commit pulse.
- FIFO_WR_FAIL_O, out, 1, rollback pulse.
- FIFO_WR_FULL_I, in, 1, FIFO prog-full.
- FIFO_WR_EN_VALID_I, in, 1, the FIFO accepted the current FIFO_WR_EN_O.
- GRANT_O, out, 2, one-hot owner of the FIFO write port.
- BUSY_O, out, 1, high when the FSM is not in IDLE.
- PKT_OK_CNT_O, out, C_CNT_WIDTH, count of committed packets.
- PKT_FAIL_CNT_O, out, C_CNT_WIDTH, count of rolled-back packets.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, XFER, DRAIN, DONE.
REQ-004 In IDLE with any VALID_I high, the FSM SHALL register a one-hot grant and enter XFER on the next cycle.
- If both requesters are valid, the grant goes to the requester not granted last (round-robin).
- After reset, S0 has priority.
REQ-005 READY_O of the granted requester SHALL equal (state==XFER) & ~FIFO_WR_FULL_I; the non-granted READY_O SHALL be 0.
REQ-006 A handshake in cycle t SHALL produce FIFO_WR_EN_O=1 and FIFO_WR_DATA_O=word in cycle t+1 (registered, latency 1); FIFO_WR_DATA_O SHALL hold its value otherwise.
REQ-007 A word counter SHALL clear on grant and increment per handshake; it saturates at C_MAX_PKT_WORDS.
REQ-008 A handshake with LAST_I=1 SHALL move XFER to DRAIN with the result flag set to "ok".
REQ-009 The packet SHALL be failed and the FSM SHALL move XFER to DRAIN with the flag set to "fail" on any of the following:
- the granted ABORT_I is high, including in the same cycle as a VALID handshake; that word is discarded and not written;
- a non-last handshake arrives when the count is already C_MAX_PKT_WORDS; that word is discarded;
- C_TIMEOUT_CYCLES consecutive XFER cycles pass without a handshake (the timer clears on each handshake);
- FIFO_WR_EN_O=1 while FIFO_WR_EN_VALID_I=0 (overflow); this is checked in XFER and DRAIN.
REQ-010 DRAIN SHALL last exactly one cycle; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-011 In DONE, exactly one of FIFO_WR_SUCC_O / FIFO_WR_FAIL_O SHALL be high (per the flag), and the matching counter SHALL increment, wrapping modulo 2^C_CNT_WIDTH.
REQ-012 For a last handshake in cycle t, timing SHALL be:
- FIFO_WR_EN_O high at t+1;
- FIFO_WR_SUCC_O high at t+2;
- earliest next grant registered at t+3.
REQ-013 ABORT_I of the non-granted requester SHALL be ignored; ABORT_I in IDLE SHALL be ignored.
REQ-014 GRANT_O SHALL hold from XFER through DONE and SHALL be 0 in IDLE.
REQ-015 SUCC_O and FAIL_O SHALL never be high simultaneously, and SHALL never be high outside DONE.

Reset
REQ-016 With RST_N_I low, all outputs SHALL be 0 immediately, and the FSM, grant history (S0 priority), counters and timer SHALL clear.
REQ-017 Reset asserted mid-packet SHALL NOT emit SUCC_O or FAIL_O; the partial packet is left for the FIFO's own reset to discard.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the result-flag constants.
REQ-019 The round-robin grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- S0 sends a 4-word packet 0x1..0x4 with LAST on 0x4 -> 4 WR_EN pulses with data in order, SUCC_O at last+2, PKT_OK_CNT_O=1.
- S0 and S1 both valid in IDLE after reset -> S0 is granted first, S1 is granted after S0's DONE, GRANT_O=01 then 10.
- S1 sends 3 words then ABORT together with VALID -> 3 WR_EN pulses, FAIL_O one cycle, PKT_FAIL_CNT_O=1, 4th word not written.
- With C_MAX_PKT_WORDS=8, send 9 words with no LAST -> 8 writes, FAIL_O, 9th word discarded.
- FIFO_WR_FULL_I held high for 10 cycles mid-packet -> READY_O=0 and no WR_EN during the hold; packet completes afterward with SUCC_O.
- No handshake for C_TIMEOUT_CYCLES=16 -> FAIL_O in cycle 18 after the last handshake; RST_N_I low mid-packet -> no SUCC/FAIL, all outputs 0.

Source files
------------

// File: rtl/fifo_wr_pkt_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_pkt_arb_pkg: FSM state encoding and packet result flags. Rev 1.0
// ----------------------------------------------------------------------------
package fifo_wr_pkt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    RES_OK   = 1'b0,
    RES_FAIL = 1'b1
  } result_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_pkt_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_pkt_arb_if: requester ports, FIFO write port and status bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface fifo_wr_pkt_arb_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 16
);
  logic                    S0_VALID_I;
  logic [C_DATA_WIDTH-1:0] S0_DATA_I;
  logic                    S0_LAST_I;
  logic                    S0_ABORT_I;
  logic                    S0_READY_O;
  logic                    S1_VALID_I;
  logic [C_DATA_WIDTH-1:0] S1_DATA_I;
  logic                    S1_LAST_I;
  logic                    S1_ABORT_I;
  logic                    S1_READY_O;
  logic                    FIFO_WR_EN_O;
  logic [C_DATA_WIDTH-1:0] FIFO_WR_DATA_O;
  logic                    FIFO_WR_SUCC_O;
  logic                    FIFO_WR_FAIL_O;
  logic                    FIFO_WR_FULL_I;
  logic                    FIFO_WR_EN_VALID_I;
  logic [1:0]              GRANT_O;
  logic                    BUSY_O;
  logic [C_CNT_WIDTH-1:0]  PKT_OK_CNT_O;
  logic [C_CNT_WIDTH-1:0]  PKT_FAIL_CNT_O;

  // Arbiter side
  modport slave (
    input  S0_VALID_I, S0_DATA_I, S0_LAST_I, S0_ABORT_I,
    input  S1_VALID_I, S1_DATA_I, S1_LAST_I, S1_ABORT_I,
    input  FIFO_WR_FULL_I, FIFO_WR_EN_VALID_I,
    output S0_READY_O, S1_READY_O,
    output FIFO_WR_EN_O, FIFO_WR_DATA_O, FIFO_WR_SUCC_O, FIFO_WR_FAIL_O,
    output GRANT_O, BUSY_O, PKT_OK_CNT_O, PKT_FAIL_CNT_O
  );

  // Requester / FIFO environment side
  modport master (
    output S0_VALID_I, S0_DATA_I, S0_LAST_I, S0_ABORT_I,
    output S1_VALID_I, S1_DATA_I, S1_LAST_I, S1_ABORT_I,
    output FIFO_WR_FULL_I, FIFO_WR_EN_VALID_I,
    input  S0_READY_O, S1_READY_O,
    input  FIFO_WR_EN_O, FIFO_WR_DATA_O, FIFO_WR_SUCC_O, FIFO_WR_FAIL_O,
    input  GRANT_O, BUSY_O, PKT_OK_CNT_O, PKT_FAIL_CNT_O
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_pkt_arb_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2: two-way round-robin arbiter, S0 favoured out of reset. Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  wire logic       i_clk,
  input  wire logic       i_rst_n,
  input  wire logic [1:0] i_req,
  input  wire logic       i_load,
  output logic      [1:0] o_grant
);
  // High when S1 won the most recent arbitration
  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_load && (|i_req)) begin
      r_last <= o_grant[1];
    end
  end
endmodule
`default_nettype wire

// File: rtl/fifo_wr_pkt_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_pkt_arb: packet arbiter for a commit/rollback-capable FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module fifo_wr_pkt_arb
  import fifo_wr_pkt_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_MAX_PKT_WORDS  = 1024,
  parameter int C_TIMEOUT_CYCLES = 4096,
  parameter int C_CNT_WIDTH      = 16
) (
  input wire logic         CLK_I,
  input wire logic         RST_N_I,
  fifo_wr_pkt_arb_if.slave bus
);
  localparam int C_WCNT_W = $clog2(C_MAX_PKT_WORDS + 1);
  localparam int C_TMR_W  = $clog2(C_TIMEOUT_CYCLES + 1);

  state_t                  r_state;
  result_t                 r_flag;
  logic [1:0]              r_grant;
  logic [C_WCNT_W-1:0]     r_wcnt;
  logic [C_TMR_W-1:0]      r_timer;
  logic                    r_wr_en;
  logic [C_DATA_WIDTH-1:0] r_wr_data;
  logic                    r_succ;
  logic                    r_fail;
  logic [C_CNT_WIDTH-1:0]  r_ok_cnt;
  logic [C_CNT_WIDTH-1:0]  r_fail_cnt;

  logic [1:0]              w_req;
  logic [1:0]              w_arb_grant;
  logic                    w_valid;
  logic                    w_last;
  logic                    w_abort;
  logic [C_DATA_WIDTH-1:0] w_data;
  logic                    w_ready;
  logic                    w_hs;
  logic                    w_ovf;
  logic                    w_at_max;
  logic                    w_timeout;

  assign w_req = {bus.S1_VALID_I, bus.S0_VALID_I};

  rr_arb2 u_rr_arb2 (
    .i_clk   (CLK_I),
    .i_rst_n (RST_N_I),
    .i_req   (w_req),
    .i_load  (r_state == ST_IDLE),
    .o_grant (w_arb_grant)
  );

  // Owner mux; only consulted while a grant is held
  assign w_valid   = r_grant[1] ? bus.S1_VALID_I : bus.S0_VALID_I;
  assign w_last    = r_grant[1] ? bus.S1_LAST_I  : bus.S0_LAST_I;
  assign w_abort   = r_grant[1] ? bus.S1_ABORT_I : bus.S0_ABORT_I;
  assign w_data    = r_grant[1] ? bus.S1_DATA_I  : bus.S0_DATA_I;
  assign w_ready   = (r_state == ST_XFER) & ~bus.FIFO_WR_FULL_I;
  assign w_hs      = w_valid & w_ready;
  assign w_ovf     = r_wr_en & ~bus.FIFO_WR_EN_VALID_I;
  assign w_at_max  = (r_wcnt == C_WCNT_W'(C_MAX_PKT_WORDS));
  assign w_timeout = (r_timer == C_TMR_W'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state    <= ST_IDLE;
      r_flag     <= RES_OK;
      r_grant    <= 2'b00;
      r_wcnt     <= '0;
      r_timer    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_succ     <= 1'b0;
      r_fail     <= 1'b0;
      r_ok_cnt   <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_succ  <= 1'b0;
      r_fail  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant <= w_arb_grant;
            r_wcnt  <= '0;
            r_timer <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_abort || w_ovf) begin
            r_flag  <= RES_FAIL;
            r_state <= ST_DRAIN;
          end else if (w_hs) begin
            r_timer <= '0;
            // A non-last word beyond the packet limit is dropped, not written
            if (w_last || !w_at_max) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_data;
              if (!w_at_max) begin
                r_wcnt <= r_wcnt + C_WCNT_W'(1);
              end
            end
            if (w_last) begin
              r_flag  <= RES_OK;
              r_state <= ST_DRAIN;
            end else if (w_at_max) begin
              r_flag  <= RES_FAIL;
              r_state <= ST_DRAIN;
            end
          end else if (w_timeout) begin
            r_flag  <= RES_FAIL;
            r_state <= ST_DRAIN;
          end else begin
            r_timer <= r_timer + C_TMR_W'(1);
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          // The final word may still be refused by the FIFO here
          if (w_ovf || (r_flag == RES_FAIL)) begin
            r_fail     <= 1'b1;
            r_fail_cnt <= r_fail_cnt + C_CNT_WIDTH'(1);
          end else begin
            r_succ   <= 1'b1;
            r_ok_cnt <= r_ok_cnt + C_CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.S0_READY_O     = w_ready & r_grant[0];
  assign bus.S1_READY_O     = w_ready & r_grant[1];
  assign bus.FIFO_WR_EN_O   = r_wr_en;
  assign bus.FIFO_WR_DATA_O = r_wr_data;
  assign bus.FIFO_WR_SUCC_O = r_succ;
  assign bus.FIFO_WR_FAIL_O = r_fail;
  assign bus.GRANT_O        = r_grant;
  assign bus.BUSY_O         = (r_state != ST_IDLE);
  assign bus.PKT_OK_CNT_O   = r_ok_cnt;
  assign bus.PKT_FAIL_CNT_O = r_fail_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_pkt_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_wr_pkt_arb: directed bench with packet-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_fifo_wr_pkt_arb;
  localparam int C_MAX = 8;
  localparam int C_TO  = 16;
  localparam int P_IDLE = 0, P_ACT = 1, P_CLOSE = 2, P_REPORT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic full = 1'b0;
  logic inj = 1'b0;
  logic        tb_v [2];
  logic        tb_l [2];
  logic        tb_a [2];
  logic [31:0] tb_d [2];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  fifo_wr_pkt_arb_if #(.C_DATA_WIDTH(32), .C_CNT_WIDTH(16)) bus ();

  fifo_wr_pkt_arb #(
    .C_DATA_WIDTH(32), .C_MAX_PKT_WORDS(C_MAX),
    .C_TIMEOUT_CYCLES(C_TO), .C_CNT_WIDTH(16)
  ) dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (bus)
  );

  assign bus.S0_VALID_I = tb_v[0];
  assign bus.S0_LAST_I  = tb_l[0];
  assign bus.S0_ABORT_I = tb_a[0];
  assign bus.S0_DATA_I  = tb_d[0];
  assign bus.S1_VALID_I = tb_v[1];
  assign bus.S1_LAST_I  = tb_l[1];
  assign bus.S1_ABORT_I = tb_a[1];
  assign bus.S1_DATA_I  = tb_d[1];
  assign bus.FIFO_WR_FULL_I     = full;
  assign bus.FIFO_WR_EN_VALID_I = bus.FIFO_WR_EN_O & ~inj;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: packet phases, owner history and expected outputs
  int m_phase = P_IDLE, m_owner = 0, m_prev = 1, m_words = 0, m_idle = 0;
  bit m_bad = 1'b0, m_ovf = 1'b0;
  logic        e_wr_en = 1'b0, e_succ = 1'b0, e_fail = 1'b0;
  logic [31:0] e_wr_data = '0;
  logic [15:0] e_nok = '0, e_nfail = '0;

  task m_reset();
    m_phase = P_IDLE; m_prev = 1; m_owner = 0; m_words = 0; m_idle = 0; m_bad = 0;
    e_wr_en = 0; e_succ = 0; e_fail = 0; e_wr_data = '0; e_nok = '0; e_nfail = '0;
  endtask

  task m_step();
    m_ovf = e_wr_en && inj;
    e_wr_en = 0; e_succ = 0; e_fail = 0;
    case (m_phase)
      P_IDLE: if (tb_v[0] || tb_v[1]) begin
        m_owner = (tb_v[0] && tb_v[1]) ? 1 - m_prev : (tb_v[0] ? 0 : 1);
        m_prev  = m_owner;
        m_words = 0; m_idle = 0; m_phase = P_ACT;
      end
      P_ACT: begin
        if (tb_a[m_owner] || m_ovf) begin
          m_bad = 1; m_phase = P_CLOSE;
        end else if (tb_v[m_owner] && !full) begin
          m_idle = 0;
          if (tb_l[m_owner]) begin
            e_wr_en = 1; e_wr_data = tb_d[m_owner]; m_bad = 0; m_phase = P_CLOSE;
          end else if (m_words >= C_MAX) begin
            m_bad = 1; m_phase = P_CLOSE;
          end else begin
            e_wr_en = 1; e_wr_data = tb_d[m_owner]; m_words++;
          end
        end else begin
          m_idle++;
          if (m_idle >= C_TO) begin m_bad = 1; m_phase = P_CLOSE; end
        end
      end
      P_CLOSE: begin
        if (m_ovf) m_bad = 1;
        if (m_bad) begin e_fail = 1; e_nfail++; end
        else begin e_succ = 1; e_nok++; end
        m_phase = P_REPORT;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare plus logs of what the DUT actually did
  logic [31:0] wr_q [$];
  logic [1:0]  g_q [$];
  logic [1:0]  g_prev = 2'b00;
  int last_hs_cyc = 0, last_end_cyc = 0, succ_cyc = 0, fail_cyc = 0, n_pulses = 0;

  initial forever begin
    logic [1:0] x_grant;
    logic       x_act;
    @(negedge clk);
    x_act   = rst_n && (m_phase == P_ACT);
    x_grant = (rst_n && m_phase != P_IDLE) ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00;
    chk("grant",    bus.GRANT_O, x_grant);
    chk("busy",     bus.BUSY_O, rst_n && m_phase != P_IDLE);
    chk("s0_ready", bus.S0_READY_O, x_act && !full && m_owner == 0);
    chk("s1_ready", bus.S1_READY_O, x_act && !full && m_owner == 1);
    chk("wr_en",    bus.FIFO_WR_EN_O, rst_n && e_wr_en);
    chk("wr_data",  bus.FIFO_WR_DATA_O, rst_n ? e_wr_data : 32'h0);
    chk("succ",     bus.FIFO_WR_SUCC_O, rst_n && e_succ);
    chk("fail",     bus.FIFO_WR_FAIL_O, rst_n && e_fail);
    chk("ok_cnt",   bus.PKT_OK_CNT_O, rst_n ? e_nok : 16'h0);
    chk("fail_cnt", bus.PKT_FAIL_CNT_O, rst_n ? e_nfail : 16'h0);
    if (bus.FIFO_WR_EN_O) wr_q.push_back(bus.FIFO_WR_DATA_O);
    if (bus.GRANT_O !== g_prev && bus.GRANT_O != 2'b00) g_q.push_back(bus.GRANT_O);
    g_prev = bus.GRANT_O;
    if ((bus.S0_VALID_I && bus.S0_READY_O) || (bus.S1_VALID_I && bus.S1_READY_O)) begin
      last_hs_cyc = cyc;
      if ((bus.S0_READY_O && bus.S0_LAST_I) || (bus.S1_READY_O && bus.S1_LAST_I))
        last_end_cyc = cyc;
    end
    if (bus.FIFO_WR_SUCC_O) begin succ_cyc = cyc; n_pulses++; end
    if (bus.FIFO_WR_FAIL_O) begin fail_cyc = cyc; n_pulses++; end
  end

  task automatic send_word(input int p, input logic [31:0] d, input logic l);
    bit hs = 0;
    tb_d[p] = d; tb_l[p] = l; tb_v[p] = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = (p == 1) ? bus.S1_READY_O : bus.S0_READY_O;
      @(posedge clk); #1;
    end
    if (!hs) chk("send_timeout", 0, 1);
    tb_v[p] = 1'b0; tb_l[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.BUSY_O;
    end
    if (!idle) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 2; i++) begin
      tb_v[i] = 0; tb_l[i] = 0; tb_a[i] = 0; tb_d[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_grant", bus.GRANT_O, 2'b00);
    chk("reset_counters", {bus.PKT_OK_CNT_O, bus.PKT_FAIL_CNT_O}, 32'h0);

    // Both requesters valid straight after reset
    g_q.delete();
    fork
      begin send_word(0, 32'hA0, 0); send_word(0, 32'hA1, 1); end
      begin send_word(1, 32'hB0, 0); send_word(1, 32'hB1, 1); end
    join
    wait_idle();
    chk("grant_order_len", g_q.size(), 2);
    if (g_q.size() == 2) begin
      chk("grant_first", g_q[0], 2'b01);
      chk("grant_second", g_q[1], 2'b10);
    end

    // S0 four-word packet after a fresh reset
    do_reset();
    wr_q.delete();
    for (int i = 1; i <= 4; i++) send_word(0, i, i == 4);
    wait_idle();
    chk("pkt4_writes", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("pkt4_data", wr_q[i], i + 1);
    chk("pkt4_succ_latency", succ_cyc - last_end_cyc, 2);
    chk("pkt4_ok_cnt", bus.PKT_OK_CNT_O, 1);

    // S1 three words, then abort alongside a fourth word
    wr_q.delete();
    for (int i = 0; i < 3; i++) send_word(1, 32'h11 + i, 0);
    tb_d[1] = 32'h14; tb_v[1] = 1; tb_a[1] = 1;
    @(posedge clk); #1;
    tb_v[1] = 0; tb_a[1] = 0;
    wait_idle();
    chk("abort_writes", wr_q.size(), 3);
    if (wr_q.size() > 0) chk("abort_last_written", wr_q[wr_q.size()-1], 32'h13);
    chk("abort_fail_cnt", bus.PKT_FAIL_CNT_O, 1);

    // Nine words without LAST against an eight-word limit
    wr_q.delete();
    for (int i = 0; i < 9; i++) send_word(0, 32'h20 + i, 0);
    wait_idle();
    chk("max_writes", wr_q.size(), 8);
    if (wr_q.size() > 0) chk("max_last_written", wr_q[wr_q.size()-1], 32'h27);
    chk("max_fail_cnt", bus.PKT_FAIL_CNT_O, 2);

    // FIFO full for ten cycles in the middle of a packet
    send_word(0, 32'h31, 0);
    send_word(0, 32'h32, 0);
    @(negedge clk);
    @(posedge clk); #1;
    full = 1'b1;
    n0 = wr_q.size();
    fork
      send_word(0, 32'h33, 1);
      begin
        @(negedge clk);
        chk("full_ready_low", bus.S0_READY_O, 0);
        repeat (9) @(negedge clk);
        chk("full_no_writes", wr_q.size(), n0);
        @(posedge clk); #1;
        full = 1'b0;
      end
    join
    wait_idle();
    chk("full_ok_cnt", bus.PKT_OK_CNT_O, 2);

    // Idle timeout after one handshake
    send_word(1, 32'h40, 0);
    wait_idle();
    chk("timeout_latency", fail_cyc - last_hs_cyc, 18);
    chk("timeout_fail_cnt", bus.PKT_FAIL_CNT_O, 3);

    // FIFO refuses a write
    inj = 1'b1;
    send_word(0, 32'h55, 0);
    wait_idle();
    inj = 1'b0;
    chk("ovf_fail_cnt", bus.PKT_FAIL_CNT_O, 4);

    // Reset in the middle of a packet
    send_word(0, 32'h71, 0);
    send_word(0, 32'h72, 0);
    n0 = n_pulses;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero",
        {bus.GRANT_O, bus.BUSY_O, bus.S0_READY_O, bus.S1_READY_O, bus.FIFO_WR_EN_O,
         bus.FIFO_WR_SUCC_O, bus.FIFO_WR_FAIL_O, bus.FIFO_WR_DATA_O}, 64'h0);
    chk("rst_counters_zero", {bus.PKT_OK_CNT_O, bus.PKT_FAIL_CNT_O}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_pulse", n_pulses, n0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
